// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared constants for the EX HI/LO sequencer
// Purpose: op_type codes, FSM state encodings and the divide-by-zero LO value
//          shared by muldiv_ctrl and anything decoding its op_type field.
// Ports:   none (package).
package muldiv_ctrl_pkg;

    // Decoded op_type field
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // LO value written for a divide by zero (HI receives the dividend)
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage sequencer for the multiplier and iterative divider
// Purpose: accepts one mult/multu/div/divu op, drives the external unit with
//          latched operands, stalls EX until the result is captured, then
//          presents one HI/LO write that is held until EX advances.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op_valid/op_type/op_a/op_b decoded op from EX
//   flush, ex_adv              cancel in-flight op; EX advance at end of cycle
//   mul_signed/mul_ina/mul_inb/mul_result   external multiplier interface
//   div_start/div_signed/div_opdata1/div_opdata2/div_annul/div_result/div_ready
//                              external divider interface
//   stallreq                   EX stall request
//   hilo_we, hi_o, lo_o        HI/LO write port
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    input  logic            flush,
    input  logic            ex_adv,
    output logic            mul_signed,
    output logic [DW-1:0]   mul_ina,
    output logic [DW-1:0]   mul_inb,
    input  logic [2*DW-1:0] mul_result,
    output logic            div_start,
    output logic            div_signed,
    output logic [DW-1:0]   div_opdata1,
    output logic [DW-1:0]   div_opdata2,
    output logic            div_annul,
    input  logic [2*DW-1:0] div_result,
    input  logic            div_ready,
    output logic            stallreq,
    output logic            hilo_we,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o
);

    localparam logic [2:0] LAT = 3'(MUL_LAT);

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    type_q, type_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;

    logic in_idle, in_mul, in_div, in_done;

    // Outputs are forced low while rst is asserted, including the first
    // reset cycle before the state register has been cleared.
    assign in_idle = ~rst & (state_q == ST_IDLE);
    assign in_mul  = ~rst & (state_q == ST_MUL);
    assign in_div  = ~rst & (state_q == ST_DIV);
    assign in_done = ~rst & (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        type_d = op_type;
                        a_d    = op_a;
                        b_d    = op_b;
                        if (op_type == MD_MULT || op_type == MD_MULTU) begin
                            state_d = ST_MUL;
                            cnt_d   = LAT;
                        end else if (op_b == '0) begin
                            // Divide by zero never starts the divider.
                            hi_d    = op_a;
                            lo_d    = DW'(DIV0_LO);
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == 3'd0) begin
                        {hi_d, lo_d} = mul_result;
                        state_d      = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_DIV: begin
                    if (div_ready) begin
                        {hi_d, lo_d} = div_result;
                        state_d      = ST_DONE;
                    end
                end
                default: begin
                    // DONE ignores op_valid so the same op is never relaunched.
                    if (ex_adv) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            type_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stallreq    = (in_idle & op_valid & ~flush) | in_mul | in_div;

    assign mul_signed  = in_mul & ~type_q[0];
    assign mul_ina     = in_mul ? a_q : '0;
    assign mul_inb     = in_mul ? b_q : '0;

    // Start drops in the ready cycle so the divider does not relaunch.
    assign div_start   = in_div & ~div_ready & ~flush;
    assign div_signed  = in_div & ~type_q[0];
    assign div_opdata1 = in_div ? a_q : '0;
    assign div_opdata2 = in_div ? b_q : '0;
    assign div_annul   = in_div & flush;

    assign hilo_we     = in_done & ~flush;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = 2'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        ex_adv = 1'b0;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result = '0;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result;
    logic        stallreq, hilo_we;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;
    logic        prev_we = 1'b0;
    int          dcnt = 0;

    muldiv_ctrl #(.MUL_LAT(1), .DW(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .op_a(op_a), .op_b(op_b), .flush(flush), .ex_adv(ex_adv),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_annul(div_annul),
        .div_result(div_result), .div_ready(div_ready), .stallreq(stallreq),
        .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Registered multiplier: product valid one cycle after operands.
    always @(posedge clk) begin
        if (mul_signed)
            mul_result <= {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
        else
            mul_result <= {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    // Divider: ready after 33 cycles of start, i.e. in the 34th DIV cycle.
    always @(posedge clk) begin
        if (rst || div_annul || div_ready) dcnt <= 0;
        else if (div_start) dcnt <= dcnt + 1;
    end
    assign div_ready = (dcnt == 33);

    always_comb begin
        div_result = '0;
        if (div_opdata2 != 32'd0) begin
            if (div_signed)
                div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                              32'($signed(div_opdata1) / $signed(div_opdata2))};
            else
                div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: first cycle of each write pops the scoreboard, held cycles
    // must repeat the same data.
    always @(negedge clk) begin
        #2;
        if (hilo_we === 1'b1) begin
            if (!prev_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL hilo_unexpected actual=%h expected=no_write", {hi_o, lo_o});
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("hilo_data", {hi_o, lo_o}, last_exp);
                end
            end else begin
                chk("hilo_hold", {hi_o, lo_o}, last_exp);
            end
        end
        prev_we = (hilo_we === 1'b1);
    end

    task automatic do_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output int n_stall, output int n_start,
                         output int n_we, output logic [31:0] ina0, output logic [31:0] ina1);
        bit done = 0;
        n_stall = 0; n_start = 0; n_we = 0; ina0 = '0; ina1 = '0;
        @(negedge clk);
        op_valid = 1'b1; op_type = t; op_a = a; op_b = b; ex_adv = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (stallreq) n_stall++;
            if (div_start) n_start++;
            if (c == 0) ina0 = mul_ina;
            if (c == 1) ina1 = mul_ina;
            if (hilo_we) begin
                n_we++;
                if (n_we > hold) begin
                    ex_adv = 1'b1;
                    done = 1;
                end
            end
            @(negedge clk);
            if (done) break;
        end
        op_valid = 1'b0; ex_adv = 1'b0;
        #1;
        chk("op_completed", 64'(done), 64'd1);
        chk("post_idle", {30'd0, stallreq, hilo_we, mul_ina}, 64'd0);
    endtask

    int ns, nst, nwe;
    logic [31:0] i0, i1;

    initial begin
        // Reset with a pending op: every output stays 0.
        op_valid = 1'b1; op_a = 32'd5; op_b = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {58'd0, stallreq, hilo_we, div_start, div_annul, mul_signed, div_signed}, 64'd0);
        chk("reset_ops", {mul_ina, div_opdata1}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        #1;
        chk("idle_stall", 64'(stallreq), 64'd0);

        // mult -3 x 5
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, ns, nst, nwe, i0, i1);
        chk("mult_stall", 64'(ns), 64'd3);
        chk("mult_we", 64'(nwe), 64'd1);

        // multu FFFFFFFF x 2
        exp_q.push_back(64'h00000001_FFFFFFFE);
        do_op(2'b01, 32'hFFFFFFFF, 32'd2, 0, ns, nst, nwe, i0, i1);
        chk("multu_ina_before", 64'(i0), 64'd0);
        chk("multu_ina_in_mul", 64'(i1), 64'hFFFFFFFF);
        chk("multu_stall", 64'(ns), 64'd3);

        // div -7 / 2
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, ns, nst, nwe, i0, i1);
        chk("div_start_cycles", 64'(nst), 64'd33);
        chk("div_stall", 64'(ns), 64'd35);
        chk("div_we", 64'(nwe), 64'd1);

        // divu 9 / 0
        exp_q.push_back(64'h00000009_FFFFFFFF);
        do_op(2'b11, 32'd9, 32'd0, 0, ns, nst, nwe, i0, i1);
        chk("div0_start", 64'(nst), 64'd0);
        chk("div0_stall", 64'(ns), 64'd1);

        // flush in the 10th DIV cycle
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b10; op_a = 32'd100; op_b = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_annul", {62'd0, div_annul, div_start}, 64'd2);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flush_idle", {61'd0, stallreq, div_start, hilo_we}, 64'd0);

        // flush in IDLE with op_valid: no launch
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b00; op_a = 32'd3; op_b = 32'd3; flush = 1'b1;
        #1;
        chk("flush_idle_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flush_idle_nolaunch", {31'd0, stallreq, mul_ina}, 64'd0);

        // mult after flush
        exp_q.push_back(64'h00000000_0000002A);
        do_op(2'b00, 32'd7, 32'd6, 0, ns, nst, nwe, i0, i1);
        chk("mult_after_flush_stall", 64'(ns), 64'd3);

        // ex_adv low for 3 DONE cycles with op_valid held
        exp_q.push_back(64'h00000000_00000008);
        do_op(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFC, 3, ns, nst, nwe, i0, i1);
        chk("hold_we_cycles", 64'(nwe), 64'd4);
        chk("hold_stall", 64'(ns), 64'd3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
